// File: rtl/intersection_sched_if.sv
// Signal bundle between the intersection scheduler and the field side.
// master: scheduler (demand inputs in, lamps/status out); slave: field.
interface intersection_sched_if;
    logic       N;
    logic       car_b;
    logic       ped_req;
    logic       a_r;
    logic       a_y;
    logic       a_g;
    logic       b_r;
    logic       b_y;
    logic       b_g;
    logic       walk;
    logic       ped_pending;
    logic [7:0] remaining;
    logic [3:0] phase;

    modport master (
        input  N, car_b, ped_req,
        output a_r, a_y, a_g, b_r, b_y, b_g,
        output walk, ped_pending, remaining, phase
    );

    modport slave (
        output N, car_b, ped_req,
        input  a_r, a_y, a_g, b_r, b_y, b_g,
        input  walk, ped_pending, remaining, phase
    );
endinterface

// File: rtl/intersection_sched.sv
// Two-road intersection phase scheduler with pedestrian phase and night flash.
// Ports: clk (1 Hz tick), rst (sync, active high), io (intersection_sched_if.master).
module intersection_sched #(
    parameter int GREEN_A = 20,
    parameter int GREEN_B = 10,
    parameter int YELLOW  = 3,
    parameter int ALLRED  = 1,
    parameter int WALK    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    intersection_sched_if.master        io
);

    typedef enum logic [3:0] {
        AG    = 4'd0,
        AY    = 4'd1,
        AR1   = 4'd2,
        PW    = 4'd3,
        BG    = 4'd4,
        BY    = 4'd5,
        AR2   = 4'd6,
        AR3   = 4'd7,
        NIGHT = 4'd8
    } state_t;

    localparam logic [7:0] GA_M1 = 8'(GREEN_A - 1);
    localparam logic [7:0] GB_M1 = 8'(GREEN_B - 1);
    localparam logic [7:0] Y_M1  = 8'(YELLOW - 1);
    localparam logic [7:0] AR_M1 = 8'(ALLRED - 1);
    localparam logic [7:0] W_M1  = 8'(WALK - 1);

    state_t     state, nxt;
    logic [7:0] rem, rem_nxt;
    logic       blink, blink_nxt;
    logic       car_l, car_nxt;
    logic       ped_l, ped_nxt;
    logic       entry;

    function automatic logic [7:0] dur_m1(state_t s);
        logic [7:0] d;
        d = 8'd0;
        unique case (s)
            AG:            d = GA_M1;
            AY, BY:        d = Y_M1;
            AR1, AR2, AR3: d = AR_M1;
            PW:            d = W_M1;
            BG:            d = GB_M1;
            default:       d = 8'd0;
        endcase
        return d;
    endfunction

    always_comb begin
        nxt = state;
        if (io.N) begin
            nxt = NIGHT;
        end else if (state == NIGHT) begin
            nxt = AR3;
        end else if (rem == 8'd0) begin
            unique case (state)
                AG:      nxt = (car_l || ped_l) ? AY : AG;
                AY:      nxt = AR1;
                AR1:     nxt = ped_l ? PW : BG;
                PW:      nxt = AR2;
                AR2:     nxt = car_l ? BG : AG;
                BG:      nxt = BY;
                BY:      nxt = AR3;
                AR3:     nxt = AG;
                default: nxt = AR3;
            endcase
        end
    end

    // AG resting at zero is not a re-entry, so the timer stays at 0.
    assign entry = (nxt != state);

    always_comb begin
        rem_nxt = 8'd0;
        if (nxt == NIGHT)
            rem_nxt = 8'd0;
        else if (entry)
            rem_nxt = dur_m1(nxt);
        else if (rem != 8'd0)
            rem_nxt = rem - 8'd1;
    end

    always_comb begin
        blink_nxt = blink;
        if (io.N)
            blink_nxt = (state == NIGHT) ? ~blink : 1'b1;
    end

    // Clearing on phase entry overrides a same-clock request.
    always_comb begin
        car_nxt = car_l | io.car_b;
        ped_nxt = ped_l | io.ped_req;
        if (nxt == BG && state != BG)
            car_nxt = 1'b0;
        if (nxt == PW && state != PW)
            ped_nxt = 1'b0;
        if (io.N || state == NIGHT) begin
            car_nxt = 1'b0;
            ped_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= AR3;
            rem   <= AR_M1;
            blink <= 1'b1;
            car_l <= 1'b0;
            ped_l <= 1'b0;
        end else begin
            state <= nxt;
            rem   <= rem_nxt;
            blink <= blink_nxt;
            car_l <= car_nxt;
            ped_l <= ped_nxt;
        end
    end

    always_comb begin
        io.a_r  = 1'b0;
        io.a_y  = 1'b0;
        io.a_g  = 1'b0;
        io.b_r  = 1'b0;
        io.b_y  = 1'b0;
        io.b_g  = 1'b0;
        io.walk = 1'b0;
        unique case (state)
            AG: begin
                io.a_g = 1'b1;
                io.b_r = 1'b1;
            end
            AY: begin
                io.a_y = 1'b1;
                io.b_r = 1'b1;
            end
            BG: begin
                io.a_r = 1'b1;
                io.b_g = 1'b1;
            end
            BY: begin
                io.a_r = 1'b1;
                io.b_y = 1'b1;
            end
            PW: begin
                io.a_r  = 1'b1;
                io.b_r  = 1'b1;
                io.walk = 1'b1;
            end
            NIGHT: begin
                io.a_y = blink;
                io.b_y = blink;
            end
            default: begin
                io.a_r = 1'b1;
                io.b_r = 1'b1;
            end
        endcase
    end

    assign io.ped_pending = ped_l;
    assign io.remaining   = rem;
    assign io.phase       = state;

endmodule

// File: tb/tb_intersection_sched.sv
// Testbench for intersection_sched: directed scenarios then random demand,
// checked every clock against a phase/elapsed-time reference model.
module tb_intersection_sched;

    localparam int GA = 20;
    localparam int GB = 10;
    localparam int YL = 3;
    localparam int AR = 1;
    localparam int WK = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    intersection_sched_if bus ();

    intersection_sched #(
        .GREEN_A(GA), .GREEN_B(GB), .YELLOW(YL), .ALLRED(AR), .WALK(WK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (bus)
    );

    always #5 clk = ~clk;

    // Reference model: current phase, clocks spent in it, latches, blink.
    int dur [9] = '{GA, YL, AR, WK, GB, YL, AR, AR, 1};
    int ph  = 7;
    int el  = 0;
    bit bl  = 1'b1;
    bit car = 1'b0;
    bit ped = 1'b0;

    function automatic int succ(int p, bit c, bit pd);
        case (p)
            0: return (c || pd) ? 1 : 0;
            1: return 2;
            2: return pd ? 3 : 4;
            3: return 6;
            4: return 5;
            5: return 7;
            6: return c ? 4 : 0;
            default: return 0;
        endcase
    endfunction

    // {a_r,a_y,a_g,b_r,b_y,b_g,walk}
    function automatic logic [6:0] lamps(int p, bit b);
        case (p)
            0: return 7'b0011000;
            1: return 7'b0101000;
            3: return 7'b1001001;
            4: return 7'b1000010;
            5: return 7'b1000100;
            8: return {1'b0, b, 2'b00, b, 2'b00};
            default: return 7'b1001000;
        endcase
    endfunction

    task automatic model_update();
        int np;
        bit c_in;
        bit p_in;
        c_in = bus.car_b;
        p_in = bus.ped_req;
        if (rst) begin
            ph = 7; el = 0; bl = 1'b1; car = 1'b0; ped = 1'b0;
        end else if (bus.N) begin
            bl  = (ph == 8) ? ~bl : 1'b1;
            ph  = 8; el = 0; car = 1'b0; ped = 1'b0;
        end else if (ph == 8) begin
            ph = 7; el = 0; car = 1'b0; ped = 1'b0;
        end else begin
            np = (el >= dur[ph] - 1) ? succ(ph, car, ped) : ph;
            car = car | c_in;
            ped = ped | p_in;
            if (np == 4 && ph != 4) car = 1'b0;
            if (np == 3 && ph != 3) ped = 1'b0;
            el = (np == ph) ? el + 1 : 0;
            ph = np;
        end
    endtask

    task automatic check();
        logic [6:0] got_l;
        int         exp_r;
        exp_r = (ph == 8 || el >= dur[ph] - 1) ? 0 : dur[ph] - 1 - el;
        got_l = {bus.a_r, bus.a_y, bus.a_g, bus.b_r, bus.b_y, bus.b_g, bus.walk};
        tests++;
        assert (bus.phase === 4'(ph)) else begin
            fails++;
            $error("FAIL phase got=%0d exp=%0d t=%0t", bus.phase, ph, $time);
        end
        tests++;
        assert (got_l === lamps(ph, bl)) else begin
            fails++;
            $error("FAIL lamps got=%b exp=%b t=%0t", got_l, lamps(ph, bl), $time);
        end
        tests++;
        assert (bus.remaining === 8'(exp_r)) else begin
            fails++;
            $error("FAIL remaining got=%0d exp=%0d t=%0t", bus.remaining, exp_r, $time);
        end
        tests++;
        assert (bus.ped_pending === ped) else begin
            fails++;
            $error("FAIL ped_pending got=%b exp=%b t=%0t", bus.ped_pending, ped, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check();
    endtask

    task automatic wait_ph(int p);
        for (int i = 0; i < 100 && ph != p; i++) step();
        tests++;
        assert (bus.phase === 4'(p)) else begin
            fails++;
            $error("FAIL wait_phase%0d got=%0d t=%0t", p, bus.phase, $time);
        end
    endtask

    initial begin
        bus.N       = 1'b0;
        bus.car_b   = 1'b0;
        bus.ped_req = 1'b0;
        rst         = 1'b1;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        // Idle: AR3 then AG resting at 0.
        repeat (30) step();
        // Car only, pulse a few clocks into a fresh AG.
        wait_ph(0);
        repeat (5) step();
        bus.car_b = 1'b1;
        step();
        bus.car_b = 1'b0;
        repeat (45) step();
        // Pedestrian only while AG rests.
        wait_ph(0);
        repeat (25) step();
        bus.ped_req = 1'b1;
        step();
        bus.ped_req = 1'b0;
        repeat (20) step();
        // Both demands.
        wait_ph(0);
        bus.car_b   = 1'b1;
        bus.ped_req = 1'b1;
        step();
        bus.car_b   = 1'b0;
        bus.ped_req = 1'b0;
        wait_ph(3);
        // Re-request in the 3rd walk clock.
        step();
        bus.ped_req = 1'b1;
        step();
        bus.ped_req = 1'b0;
        wait_ph(0);
        // Request coinciding with the PW-entry clock.
        wait_ph(2);
        bus.ped_req = 1'b1;
        step();
        bus.ped_req = 1'b0;
        repeat (3) step();
        // Night mode during BG.
        wait_ph(0);
        bus.car_b = 1'b1;
        step();
        bus.car_b = 1'b0;
        wait_ph(4);
        repeat (3) step();
        bus.N = 1'b1;
        repeat (6) step();
        bus.N = 1'b0;
        repeat (30) step();
        // Reset in the middle of a walk.
        bus.ped_req = 1'b1;
        step();
        bus.ped_req = 1'b0;
        wait_ph(3);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (5) step();
        // Random demand, night and reset.
        for (int i = 0; i < 4000; i++) begin
            bus.car_b   = ($urandom_range(0, 29) == 0);
            bus.ped_req = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 149) == 0) bus.N = ~bus.N;
            rst = ($urandom_range(0, 599) == 0);
            step();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/intersection_sched.md
Name: intersection_sched

Overview:
- Phase scheduler for a two-road intersection: main road A, side road B, plus a pedestrian crossing.
- Sequences the red/yellow/green lamps for both roads and the walk lamp.
- Arbitrates between side-road car demand and pedestrian demand; main road rests on green when there is no demand.
- Runs from the 1 Hz system tick, so one clock equals one second. Provides N-driven night flashing.

Parameters:
- GREEN_A, 20, minimum main-road green in ticks (1..255)
- GREEN_B, 10, side-road green in ticks (1..255)
- YELLOW, 3, yellow duration for either road (1..255)
- ALLRED, 1, all-red clearance in ticks (1..255)
- WALK, 8, pedestrian walk duration (1..255)

Ports:
- clk  input  1  system clock, 1 Hz tick; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- N  input  1  night mode; level-sensitive
- car_b  input  1  side-road vehicle sensor; level or pulse
- ped_req  input  1  pedestrian button; any-length pulse
- a_r, a_y, a_g  output  1 each  road A lamps
- b_r, b_y, b_g  output  1 each  road B lamps
- walk  output  1  pedestrian walk lamp
- ped_pending  output  1  pedestrian request latched and not yet served
- remaining  output  8  ticks left in current phase
- phase  output  4  current state code

Behaviour:
- State codes: AG=0, AY=1, AR1=2, PW=3, BG=4, BY=5, AR2=6, AR3=7, NIGHT=8.
- Lamps are decoded only from the registered state, never directly from inputs:
  - AG: a_g, b_r
  - AY: a_y, b_r
  - BG: a_r, b_g
  - BY: a_r, b_y
  - AR1/AR2/AR3: a_r, b_r
  - PW: a_r, b_r, walk
  - NIGHT: a_y = b_y = blink; all other lamps 0
- Reset (rst=1 at an edge) takes priority over everything:
  - phase=AR3, remaining=ALLRED-1, blink=1
  - car latch=0, ped latch=0
  - lamps a_r=b_r=1, all others 0
- Timer:
  - On every state entry, remaining loads duration-1.
  - Otherwise it decrements by 1 per clock and saturates at 0.
  - A phase with duration D lasts exactly D clocks when its exit condition holds at remaining=0.
- Transitions, evaluated when remaining=0 and N=0:
  - AG -> AY if car latch or ped latch; otherwise stay in AG with remaining held at 0.
  - AY -> AR1.
  - AR1 -> PW if ped latch, else BG.
  - PW -> AR2.
  - AR2 -> BG if car latch, else AG.
  - BG -> BY.
  - BY -> AR3.
  - AR3 -> AG.
- Durations: AG=GREEN_A, AY/BY=YELLOW, AR1/AR2/AR3=ALLRED, PW=WALK, BG=GREEN_B.
- Car latch:
  - Set on any clock with car_b=1.
  - Cleared on the clock that enters BG; clear wins over a simultaneous set.
- Ped latch:
  - Set on any clock with ped_req=1.
  - Cleared on the clock that enters PW; clear wins over a simultaneous set.
  - A request arriving while in PW re-latches and is served on the next cycle through AG.
  - ped_pending = ped latch.
- Night mode:
  - N=1 at any edge, from any state and regardless of timer: next state NIGHT, both latches cleared, blink=1.
  - In NIGHT: blink toggles every clock, latches held clear, remaining=0.
  - N=0 while in NIGHT: next state AR3 with remaining=ALLRED-1, then normal sequence.
- Width rules:
  - remaining is 8 bits; parameters outside 1..255 are illegal.
  - No arithmetic wraps: the decrement is guarded at 0.

Test Plan:
- rst pulse, no demand -> AR3 for 1 clk (a_r=b_r=1). Then AG; remaining counts 19..0 and stays at 0 with a_g=1 indefinitely.
- car_b pulse at AG tick 5 -> AG ends after 20 clks. Then AY 3, AR1 1, BG 10 (b_g=1), BY 3, AR3 1, back to AG. Car latch clear after BG entry.
- ped_req pulse while AG resting at 0 -> next clk AY (3), AR1 (1), PW 8 clks (walk=1, ped_pending=0 from PW entry), AR2 1, AG. No BG visited.
- car_b and ped_req both set in AG -> AG, AY, AR1, PW(8), AR2, BG(10), BY, AR3, AG.
- ped_req pulse during the 3rd clock of PW -> ped_pending=1 until the following PW entry. ped_req coincident with the PW-entry clock -> ped_pending=0.
- N=1 during BG tick 4 -> next clk phase=8, a_y=b_y toggle 1,0,1,…, others 0. N=0 -> AR3 1 clk then AG; car latch 0.
- rst=1 mid-PW -> next clk phase=7, walk=0, a_r=b_r=1, ped_pending=0, remaining=0 (ALLRED-1).
